// File: rtl/z80_bus_master_if.sv
// Bus-initiator request/response handshake plus Z80 address/data/strobe bus.
// master = the initiator (z80_bus_master); slave = the requester/target side.
interface z80_bus_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_io;
  logic              req_m1;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic [DATA_W-1:0] data_in;
  logic              mreq_n;
  logic              ioreq_n;
  logic              rd_n;
  logic              wr_n;
  logic              m1_n;
  logic              rfsh_n;
  logic              wait_n;
  logic              busy;

  modport master (
    input  req_valid, req_write, req_io, req_m1, req_addr, req_wdata, data_in, wait_n,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout, address, data_out, data_oe,
           mreq_n, ioreq_n, rd_n, wr_n, m1_n, rfsh_n, busy
  );

  modport slave (
    output req_valid, req_write, req_io, req_m1, req_addr, req_wdata, data_in, wait_n,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout, address, data_out, data_oe,
           mreq_n, ioreq_n, rd_n, wr_n, m1_n, rfsh_n, busy
  );
endinterface

// File: rtl/z80_bus_master.sv
// Z80-timed memory/IO bus initiator (T1/T2/TW/T3) with WAIT handling and wait timeout.
// Optional Z80_BUS_MASTER_REFRESH_EN adds the opcode-fetch refresh phase (T3/T4) and R register.
module z80_bus_master #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int T_DIV    = 1,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  z80_bus_master_if.master bus
);

  localparam int TCW = (T_DIV > 1) ? $clog2(T_DIV) : 1;
  localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T1H,
    S_T1L,
    S_T2H,
    S_T2L,
    S_TWH,
    S_TWL,
    S_T3H,
    S_T3L
`ifdef Z80_BUS_MASTER_REFRESH_EN
    ,
    S_T4H,
    S_T4L
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [TCW-1:0]    tcnt;
  logic              t_last;
  logic [WCW-1:0]    wcnt, wcnt_nxt;
  logic              r_write, r_io, r_fetch, r_abort, abort_nxt;
  logic              accept;

  logic              wr_f, io_f, fetch_f;
  logic              act_t1l, act_t2h, act_t2l;
  logic              mreq_d, ioreq_d, rd_d, wr_d, m1_d, oe_d;

  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_oe_q;
  logic              mreq_q, ioreq_q, rd_q, wr_q, m1_q;
  logic [DATA_W-1:0] rdata_cap;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_timeout_q;

`ifdef Z80_BUS_MASTER_REFRESH_EN
  logic              rfsh_d, rfsh_q, refr;
  logic [7:0]        r_reg;
`endif

  assign t_last = (tcnt == TCW'(T_DIV - 1));

  // Next-state: every non-IDLE state advances only on its last clk.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    abort_nxt = r_abort;
    accept    = 1'b0;
    if (state == S_IDLE) begin
      if (bus.req_valid) begin
        accept    = 1'b1;
        state_nxt = S_T1H;
        wcnt_nxt  = '0;
        abort_nxt = 1'b0;
      end
    end else if (t_last) begin
      case (state)
        S_T1H: state_nxt = S_T1L;
        S_T1L: state_nxt = S_T2H;
        S_T2H: state_nxt = S_T2L;
        S_T2L: state_nxt = (r_io || !bus.wait_n) ? S_TWH : S_T3H;
        S_TWH: state_nxt = S_TWL;
        S_TWL: begin
          if (bus.wait_n) begin
            state_nxt = S_T3H;
          end else if ((MAX_WAIT != 0) && (wcnt == WCW'(MAX_WAIT))) begin
            state_nxt = S_T3L;
            abort_nxt = 1'b1;
          end else begin
            state_nxt = S_TWH;
            wcnt_nxt  = wcnt + WCW'(1);
          end
        end
        S_T3H: state_nxt = S_T3L;
`ifdef Z80_BUS_MASTER_REFRESH_EN
        S_T3L: state_nxt = (r_fetch && !r_abort) ? S_T4H : S_IDLE;
        S_T4H: state_nxt = S_T4L;
`endif
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the next state so the registered outputs line up with the state.
  always_comb begin
    wr_f    = accept ? bus.req_write : r_write;
    io_f    = accept ? bus.req_io : r_io;
    fetch_f = accept ? (bus.req_m1 & ~bus.req_io & ~bus.req_write) : r_fetch;
    act_t1l = state_nxt inside {S_T1L, S_T2H, S_T2L, S_TWH, S_TWL, S_T3H};
    act_t2h = state_nxt inside {S_T2H, S_T2L, S_TWH, S_TWL, S_T3H};
    act_t2l = state_nxt inside {S_T2L, S_TWH, S_TWL, S_T3H};
    mreq_d  = ~(~io_f & act_t1l);
    ioreq_d = ~(io_f & act_t2h);
    rd_d    = ~(~wr_f & (io_f ? act_t2h : act_t1l));
    wr_d    = ~(wr_f & (io_f ? act_t2h : act_t2l));
    m1_d    = ~(fetch_f & (act_t1l | (state_nxt == S_T1H)));
    oe_d    = wr_f & (act_t1l | (state_nxt == S_T3L));
`ifdef Z80_BUS_MASTER_REFRESH_EN
    refr    = fetch_f & ~abort_nxt;
    mreq_d  = mreq_d & ~(refr & (state_nxt inside {S_T3L, S_T4H}));
    rfsh_d  = ~(refr & (state_nxt inside {S_T3L, S_T4H, S_T4L}));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      tcnt          <= '0;
      wcnt          <= '0;
      r_write       <= 1'b0;
      r_io          <= 1'b0;
      r_fetch       <= 1'b0;
      r_abort       <= 1'b0;
      address_q     <= '0;
      data_out_q    <= '0;
      data_oe_q     <= 1'b0;
      mreq_q        <= 1'b1;
      ioreq_q       <= 1'b1;
      rd_q          <= 1'b1;
      wr_q          <= 1'b1;
      m1_q          <= 1'b1;
      rdata_cap     <= '1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '1;
      rsp_timeout_q <= 1'b0;
`ifdef Z80_BUS_MASTER_REFRESH_EN
      rfsh_q        <= 1'b1;
      r_reg         <= 8'h00;
`endif
    end else begin
      state   <= state_nxt;
      tcnt    <= ((state == S_IDLE) || t_last) ? '0 : tcnt + TCW'(1);
      wcnt    <= wcnt_nxt;
      r_abort <= abort_nxt;
      if (accept) begin
        r_write   <= bus.req_write;
        r_io      <= bus.req_io;
        r_fetch   <= bus.req_m1 & ~bus.req_io & ~bus.req_write;
        address_q <= bus.req_addr;
        if (bus.req_write) begin
          data_out_q <= bus.req_wdata;
        end
      end
`ifdef Z80_BUS_MASTER_REFRESH_EN
      else if (state == S_T3H && state_nxt == S_T3L && r_fetch) begin
        address_q <= ADDR_W'(r_reg);
      end
      if (state == S_T4L && t_last) begin
        r_reg <= {r_reg[7], r_reg[6:0] + 7'd1};
      end
      rfsh_q <= rfsh_d;
`endif
      data_oe_q <= oe_d;
      mreq_q    <= mreq_d;
      ioreq_q   <= ioreq_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      m1_q      <= m1_d;
      if (state == S_T3H && t_last) begin
        rdata_cap <= bus.data_in;
      end
      rsp_valid_q <= 1'b0;
      if (state != S_IDLE && state_nxt == S_IDLE) begin
        rsp_valid_q   <= 1'b1;
        rsp_rdata_q   <= (r_write || r_abort) ? '1 : rdata_cap;
        rsp_timeout_q <= r_abort;
      end
    end
  end

  assign bus.req_ready   = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.address     = address_q;
  assign bus.data_out    = data_out_q;
  assign bus.data_oe     = data_oe_q;
  assign bus.mreq_n      = mreq_q;
  assign bus.ioreq_n     = ioreq_q;
  assign bus.rd_n        = rd_q;
  assign bus.wr_n        = wr_q;
  assign bus.m1_n        = m1_q;
`ifdef Z80_BUS_MASTER_REFRESH_EN
  assign bus.rfsh_n      = rfsh_q;
`else
  assign bus.rfsh_n      = 1'b1;
`endif

endmodule

// File: tb/tb_z80_bus_master.sv
// Self-checking bench for z80_bus_master: directed table, reset-in-TW sequence, and random
// requests checked cycle by cycle against a phase-timeline model of the Z80 bus cycle.
module tb_z80_bus_master;

  localparam int MAXW = 4;
`ifdef Z80_BUS_MASTER_REFRESH_EN
  localparam bit RF = 1'b1;
`else
  localparam bit RF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  z80_bus_master_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  z80_bus_master #(
    .ADDR_W(16),
    .DATA_W(8),
    .T_DIV(1),
    .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        wr;
    logic        io;
    logic        m1;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  din;
    int          nw;
    int          lat;
    logic        to;
    logic [7:0]  rd;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_rd = 8'hFF;
  logic [6:0] r_model = 7'd0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act, exp);
    end
  endtask

  function automatic logic [9:0] act_vec();
    return {bus.mreq_n, bus.ioreq_n, bus.rd_n, bus.wr_n, bus.m1_n, bus.rfsh_n,
            bus.data_oe, bus.busy, bus.rsp_valid, bus.req_ready};
  endfunction

  // Wait-state count and abort from the WAIT rules: nw = consecutive low wait_n samples.
  function automatic void model(input logic io, input int nw, output int tw, output bit ab);
    int z;
    z  = io ? nw : ((nw > 0) ? nw - 1 : 0);
    ab = (MAXW != 0) && (z > MAXW);
    tw = ab ? MAXW + 1 : (io ? nw + 1 : nw);
  endfunction

  function automatic int model_lat(input logic io, input bit fetch, input int nw);
    int tw;
    bit ab;
    model(io, nw, tw, ab);
    return 4 + 2 * tw + (ab ? 1 : 2) + ((RF && fetch && !ab) ? 2 : 0);
  endfunction

  // 1=T1H 2=T1L 3=T2H 4=T2L 5=TW 6=T3H 7=T3L 8=T4H 9=T4L
  function automatic int phase(input int c, input int tw, input bit ab);
    if (c <= 4) return c;
    if (c <= 4 + 2 * tw) return 5;
    if (ab) return 7;
    return c - 4 - 2 * tw + 5;
  endfunction

  function automatic logic [9:0] exp_vec(input int p, input logic wr, input logic io,
                                         input bit fetch, input bit refr);
    bit a1, a2, a3;
    logic mreq, ioreq, rd, wrs, m1, rfsh, oe;
    a1    = (p >= 2) && (p <= 6);
    a2    = (p >= 3) && (p <= 6);
    a3    = (p >= 4) && (p <= 6);
    mreq  = !((!io && a1) || (refr && (p == 7 || p == 8)));
    ioreq = !(io && a2);
    rd    = !(!wr && (io ? a2 : a1));
    wrs   = !(wr && (io ? a2 : a3));
    m1    = !(fetch && (p >= 1) && (p <= 6));
    rfsh  = !(refr && (p >= 7));
    oe    = wr && (p >= 2) && (p <= 7);
    return {mreq, ioreq, rd, wrs, m1, rfsh, oe, 1'b1, 1'b0, 1'b0};
  endfunction

  // Called just after a negedge; returns just after the negedge of the rsp_valid cycle.
  task automatic txn(input logic wr, input logic io, input logic m1, input logic [15:0] addr,
                     input logic [7:0] wd, input logic [7:0] din, input int nw,
                     input int lat, input logic eto, input logic [7:0] erd);
    int tw, p;
    bit ab, fetch, refr;
    logic [15:0] ea;
    fetch = m1 && !io && !wr;
    model(io, nw, tw, ab);
    refr = RF && fetch && !ab;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_io    = io;
    bus.req_m1    = m1;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.wait_n    = 1'b1;
    @(posedge clk);
    #1;
    // Held or changing requests while busy must be ignored.
    bus.req_valid = 1'($urandom_range(0, 1));
    bus.req_write = 1'($urandom);
    bus.req_io    = 1'($urandom);
    bus.req_m1    = 1'($urandom);
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = 8'($urandom);
    for (int c = 1; c <= lat + 1; c++) begin
      p = (c <= lat) ? phase(c, tw, ab) : 0;
      if (nw > 0) bus.wait_n = (c <= (io ? 4 : 2) + 2 * nw) ? 1'b0 : 1'b1;
      else        bus.wait_n = 1'b1;
      bus.data_in = (p == 6) ? din : ~din;
      @(negedge clk);
      if (c <= lat) begin
        chk("strobes", c, 32'(act_vec()), 32'(exp_vec(p, wr, io, fetch, refr)));
        ea = (refr && p >= 7) ? {9'h000, r_model} : addr;
        chk("address", c, 32'(bus.address), 32'(ea));
        if (wr && p >= 2 && p <= 7) chk("data_out", c, 32'(bus.data_out), 32'(wd));
        chk("rdata_hold", c, 32'(bus.rsp_rdata), 32'(last_rd));
        if (c == lat) bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        chk("rsp_vec", c, 32'(act_vec()), 32'(10'b1111110011));
        chk("rsp_rdata", c, 32'(bus.rsp_rdata), 32'(erd));
        chk("rsp_timeout", c, 32'(bus.rsp_timeout), 32'(eto));
      end
    end
    last_rd = erd;
    if (refr) r_model = r_model + 7'd1;
  endtask

  function automatic vec_t mk(input logic wr, input logic io, input logic m1, input logic [15:0] addr,
                              input logic [7:0] wd, input logic [7:0] din, input int nw,
                              input int lat, input logic to, input logic [7:0] rd);
    vec_t v;
    v.wr = wr; v.io = io; v.m1 = m1; v.addr = addr; v.wd = wd; v.din = din;
    v.nw = nw; v.lat = lat; v.to = to; v.rd = rd;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[14];
    int   flat;
    logic wr, io, m1;
    logic [7:0] din;
    int   nw, tw, lat, gap;
    bit   ab;

    flat = RF ? 2 : 0;
    tbl[0]  = mk(0, 0, 0, 16'h1234, 8'h00, 8'hA5, 0,  6,        0, 8'hA5);
    tbl[1]  = mk(1, 1, 0, 16'h0042, 8'h3C, 8'h00, 0,  8,        0, 8'hFF);
    tbl[2]  = mk(0, 0, 0, 16'h2000, 8'h00, 8'h5A, 3,  12,       0, 8'h5A);
    tbl[3]  = mk(0, 0, 0, 16'h3000, 8'h00, 8'h11, 20, 15,       1, 8'hFF);
    tbl[4]  = mk(1, 0, 0, 16'hBEEF, 8'h77, 8'h00, 0,  6,        0, 8'hFF);
    tbl[5]  = mk(0, 1, 0, 16'h00FE, 8'h00, 8'hC3, 0,  8,        0, 8'hC3);
    tbl[6]  = mk(0, 1, 0, 16'h0080, 8'h00, 8'h96, 2,  12,       0, 8'h96);
    tbl[7]  = mk(1, 1, 0, 16'h0010, 8'h44, 8'h00, 20, 15,       1, 8'hFF);
    tbl[8]  = mk(0, 0, 0, 16'h4000, 8'h00, 8'h81, 5,  16,       0, 8'h81);
    tbl[9]  = mk(0, 1, 0, 16'h0020, 8'h00, 8'h18, 4,  16,       0, 8'h18);
    tbl[10] = mk(0, 0, 1, 16'h0100, 8'h00, 8'h3E, 0,  6 + flat, 0, 8'h3E);
    tbl[11] = mk(0, 0, 1, 16'h0101, 8'h00, 8'hED, 1,  8 + flat, 0, 8'hED);
    tbl[12] = mk(1, 0, 1, 16'h5000, 8'h66, 8'h00, 0,  6,        0, 8'hFF);
    tbl[13] = mk(1, 1, 0, 16'h0033, 8'h55, 8'h00, 5,  15,       1, 8'hFF);

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_io    = 1'b0;
    bus.req_m1    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.data_in   = '0;
    bus.wait_n    = 1'b1;
    #2;
    chk("reset_vec", 0, 32'(act_vec()), 32'(10'b1111110001));
    chk("reset_address", 0, 32'(bus.address), 32'h0);
    chk("reset_data_out", 0, 32'(bus.data_out), 32'h0);
    chk("reset_rdata", 0, 32'(bus.rsp_rdata), 32'hFF);
    chk("reset_timeout", 0, 32'(bus.rsp_timeout), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      txn(tbl[i].wr, tbl[i].io, tbl[i].m1, tbl[i].addr, tbl[i].wd, tbl[i].din,
          tbl[i].nw, tbl[i].lat, tbl[i].to, tbl[i].rd);
    end

    for (int i = 0; i < 150; i++) begin
      wr  = 1'($urandom);
      io  = 1'($urandom);
      m1  = 1'($urandom);
      din = 8'($urandom);
      nw  = $urandom_range(0, 7);
      model(io, nw, tw, ab);
      lat = model_lat(io, m1 && !io && !wr, nw);
      txn(wr, io, m1, 16'($urandom), 8'($urandom), din, nw, lat, ab,
          (wr || ab) ? 8'hFF : din);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        @(negedge clk);
        chk("idle_vec", g, 32'(act_vec()), 32'(10'b1111110001));
      end
    end

    // Reset asserted while a write sits in TWL.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_io    = 1'b0;
    bus.req_m1    = 1'b0;
    bus.req_addr  = 16'h5555;
    bus.req_wdata = 8'h99;
    bus.wait_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_wr_n", 6, 32'(bus.wr_n), 32'h0);
    chk("pre_rst_oe", 6, 32'(bus.data_oe), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid_vec", 6, 32'(act_vec()), 32'(10'b1111110001));
    chk("rst_mid_address", 6, 32'(bus.address), 32'h0);
    chk("rst_mid_data_out", 6, 32'(bus.data_out), 32'h0);
    chk("rst_mid_rdata", 6, 32'(bus.rsp_rdata), 32'hFF);
    @(negedge clk);
    rst = 1'b0;
    bus.wait_n = 1'b1;
    last_rd = 8'hFF;
    r_model = 7'd0;
    txn(tbl[0].wr, tbl[0].io, tbl[0].m1, tbl[0].addr, tbl[0].wd, tbl[0].din,
        tbl[0].nw, tbl[0].lat, tbl[0].to, tbl[0].rd);
    txn(tbl[10].wr, tbl[10].io, tbl[10].m1, tbl[10].addr, tbl[10].wd, tbl[10].din,
        tbl[10].nw, tbl[10].lat, tbl[10].to, tbl[10].rd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
